// File: rtl/vector_list_sched_if.sv
// vector_list_sched_if
//   Groups the scheduler's configuration, engine-side and ROM-side signals.
//   master : drives configuration and engine status, observes scheduler outputs
//   slave  : the scheduler itself
//   Signals:
//     enable_mask  bit i = list i eligible for selection
//     list_base    base address of list i at [i*ADDRESSWIDTH +: ADDRESSWIDTH]
//     repeat_cnt   frames per list visit (0 behaves as 1)
//     engine_addr  list-relative address from the vector engine
//     frame_drawn  engine end-of-frame level
//     rom_addr     absolute ROM address
//     engine_rst   active-high reset to the engine
//     active_list  list currently owning the engine
//     busy         engine is drawing a list
//     list_done    one-cycle pulse when a list visit completes
interface vector_list_sched_if #(
    parameter int ADDRESSWIDTH = 10,
    parameter int NLISTS       = 4,
    parameter int REPW         = 4
);
    localparam int LW = $clog2(NLISTS);

    logic [NLISTS-1:0]              enable_mask;
    logic [NLISTS*ADDRESSWIDTH-1:0] list_base;
    logic [REPW-1:0]                repeat_cnt;
    logic [ADDRESSWIDTH-1:0]        engine_addr;
    logic                           frame_drawn;
    logic [ADDRESSWIDTH-1:0]        rom_addr;
    logic                           engine_rst;
    logic [LW-1:0]                  active_list;
    logic                           busy;
    logic                           list_done;

    modport master (
        output enable_mask, list_base, repeat_cnt, engine_addr, frame_drawn,
        input  rom_addr, engine_rst, active_list, busy, list_done
    );

    modport slave (
        input  enable_mask, list_base, repeat_cnt, engine_addr, frame_drawn,
        output rom_addr, engine_rst, active_list, busy, list_done
    );
endinterface

// File: rtl/vector_list_sched.sv
// vector_list_sched
//   Round-robin frame scheduler sharing one vector display engine among
//   NLISTS vector lists in a common ROM. Picks the next enabled list, holds
//   the engine in reset for two cycles, then lets it draw until the programmed
//   number of frames has completed, and moves on.
//   Ports:
//     clk  system clock
//     rst  asynchronous active-high reset
//     bus  vector_list_sched_if.slave (configuration, engine and ROM signals)
module vector_list_sched #(
    parameter int ADDRESSWIDTH = 10,
    parameter int NLISTS       = 4,
    parameter int REPW         = 4
) (
    input  logic               clk,
    input  logic               rst,
    vector_list_sched_if.slave bus
);
    localparam int LW = $clog2(NLISTS);
    localparam logic [REPW:0] ONE_W = (REPW+1)'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DRAW  = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic                    scnt_q, scnt_d;       // START cycle counter
    logic [LW-1:0]           active_q, active_d;
    logic [ADDRESSWIDTH-1:0] base_q, base_d;
    logic [REPW-1:0]         rep_q, rep_d;
    logic [REPW-1:0]         fcnt_q, fcnt_d;       // frames completed this visit
    logic                    fdq_q, fdq_d;         // registered frame_drawn
    logic                    done_q, done_d;

    logic                    load;                 // take a new selection this edge
    logic [LW-1:0]           sel;
    logic                    fd_rise;
    logic                    last_frame;

    // Lowest enabled index strictly after cur, wrapping; the final iteration
    // revisits cur itself so a single enabled list reselects itself.
    function automatic logic [LW-1:0] pick(input logic [NLISTS-1:0] m,
                                           input logic [LW-1:0]     cur);
        logic [LW-1:0] r;
        logic          found;
        int            idx;
        r     = '0;
        found = 1'b0;
        for (int i = 1; i <= NLISTS; i++) begin
            idx = (int'(cur) + i) % NLISTS;
            if (!found && m[idx]) begin
                r     = LW'(idx);
                found = 1'b1;
            end
        end
        return r;
    endfunction

    assign sel        = pick(bus.enable_mask, active_q);
    assign fd_rise    = bus.frame_drawn & ~fdq_q;
    assign last_frame = (({1'b0, fcnt_q} + ONE_W) == {1'b0, rep_q});

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (|bus.enable_mask) begin
                    state_d = S_START;
                    load    = 1'b1;
                end
            end
            S_START: begin
                if (scnt_q) state_d = S_DRAW;
            end
            S_DRAW: begin
                // Completing frame reselects directly, skipping IDLE
                if (fd_rise && last_frame) begin
                    if (|bus.enable_mask) begin
                        state_d = S_START;
                        load    = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        bus.engine_rst = 1'b1;
        bus.busy       = 1'b0;
        if (state_q == S_DRAW) begin
            bus.engine_rst = 1'b0;
            bus.busy       = 1'b1;
        end
    end

    // ---------------- datapath next state ----------------
    always_comb begin
        scnt_d   = 1'b0;
        active_d = active_q;
        base_d   = base_q;
        rep_d    = rep_q;
        fcnt_d   = fcnt_q;
        fdq_d    = bus.frame_drawn;
        done_d   = 1'b0;
        if (state_q == S_START) begin
            scnt_d = ~scnt_q;
            fdq_d  = 1'b0;
        end
        if (state_q == S_DRAW && fd_rise) begin
            fcnt_d = fcnt_q + REPW'(1);
            done_d = last_frame;
        end
        // Configuration is only sampled here; later changes wait for the next visit
        if (load) begin
            active_d = sel;
            base_d   = bus.list_base[sel*ADDRESSWIDTH +: ADDRESSWIDTH];
            rep_d    = (bus.repeat_cnt == '0) ? REPW'(1) : bus.repeat_cnt;
            fcnt_d   = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scnt_q   <= 1'b0;
            active_q <= LW'(NLISTS - 1);   // first selection lands on list 0
            base_q   <= '0;
            rep_q    <= REPW'(1);
            fcnt_q   <= '0;
            fdq_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            scnt_q   <= scnt_d;
            active_q <= active_d;
            base_q   <= base_d;
            rep_q    <= rep_d;
            fcnt_q   <= fcnt_d;
            fdq_q    <= fdq_d;
            done_q   <= done_d;
        end
    end

    // Address translation wraps silently at 2^ADDRESSWIDTH
    assign bus.rom_addr    = base_q + bus.engine_addr;
    assign bus.active_list = active_q;
    assign bus.list_done   = done_q;

endmodule

// File: tb/tb_vector_list_sched.sv
// tb_vector_list_sched
//   Randomized self-checking bench for vector_list_sched. A visit-level model
//   (enabled-list queue, latched base/repeat) predicts the list order, address
//   mapping, frame counting and restart timing.
module tb_vector_list_sched;
    localparam int AW = 10;
    localparam int NL = 4;
    localparam int RW = 4;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_err;

    // model state
    int        m_cur;
    logic [AW-1:0] m_base;
    int        m_rep;
    bit        m_idle;

    vector_list_sched_if #(.ADDRESSWIDTH(AW), .NLISTS(NL), .REPW(RW)) bus ();

    vector_list_sched #(.ADDRESSWIDTH(AW), .NLISTS(NL), .REPW(RW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Next list: first enabled index above cur, else the lowest enabled one
    function automatic int next_sel(input logic [NL-1:0] m, input int cur);
        int q[$];
        int r;
        for (int i = 0; i < NL; i++) if (m[i]) q.push_back(i);
        r = -1;
        for (int k = q.size() - 1; k >= 0; k--) if (q[k] > cur) r = q[k];
        if (r < 0) r = q[0];
        return r;
    endfunction

    task automatic model_select(input logic [NL-1:0] nm, input logic [NL*AW-1:0] nb,
                                input logic [RW-1:0] nr);
        m_cur  = next_sel(nm, m_cur);
        m_base = nb[m_cur*AW +: AW];
        m_rep  = (nr == 0) ? 1 : int'(nr);
        m_idle = 1'b0;
    endtask

    // Called at a negedge while IDLE; returns at the negedge of the first DRAW cycle
    task automatic start_idle(input logic [NL-1:0] nm, input logic [NL*AW-1:0] nb,
                              input logic [RW-1:0] nr);
        bus.enable_mask = nm;
        bus.list_base   = nb;
        bus.repeat_cnt  = nr;
        model_select(nm, nb, nr);
        @(negedge clk);
        chk("start1_erst", 32'(bus.engine_rst), 1);
        chk("start1_busy", 32'(bus.busy), 0);
        @(negedge clk);
        chk("start2_erst", 32'(bus.engine_rst), 1);
        @(negedge clk);
        chk("draw_erst", 32'(bus.engine_rst), 0);
        chk("draw_busy", 32'(bus.busy), 1);
    endtask

    // Called at the negedge of a first DRAW cycle; plays m_rep frames, applying
    // nm/nb/nr at the completing edge, and returns at the next first DRAW
    // negedge (or one cycle into IDLE when nm is zero).
    task automatic do_visit(input logic [NL-1:0] nm, input logic [NL*AW-1:0] nb,
                            input logic [RW-1:0] nr, input bit scr);
        logic [AW-1:0] ea;
        logic [AW-1:0] exp_a;
        int            gap;
        chk("active_list", 32'(bus.active_list), 32'(m_cur));
        for (int f = 0; f < m_rep; f++) begin
            gap = $urandom_range(2, 10);
            for (int g = 0; g < gap; g++) begin
                ea = AW'($urandom);
                bus.engine_addr = ea;
                if (scr) begin
                    bus.enable_mask = NL'($urandom);
                    bus.list_base   = (NL*AW)'({$urandom, $urandom});
                    bus.repeat_cnt  = RW'($urandom);
                end
                #1;
                exp_a = m_base + ea;
                chk("rom_addr", 32'(bus.rom_addr), 32'(exp_a));
                @(negedge clk);
                chk("draw_busy", 32'(bus.busy), 1);
                chk("draw_done", 32'(bus.list_done), 0);
            end
            if (f == m_rep - 1) begin
                bus.enable_mask = nm;
                bus.list_base   = nb;
                bus.repeat_cnt  = nr;
            end
            bus.frame_drawn = 1'b1;
            @(negedge clk);
            bus.frame_drawn = 1'b0;
            if (f < m_rep - 1) begin
                chk("midframe_done", 32'(bus.list_done), 0);
                chk("midframe_busy", 32'(bus.busy), 1);
            end
        end
        chk("done_pulse", 32'(bus.list_done), 1);
        chk("switch_erst1", 32'(bus.engine_rst), 1);
        if (nm != 0) begin
            model_select(nm, nb, nr);
            @(negedge clk);
            chk("switch_done_low", 32'(bus.list_done), 0);
            chk("switch_erst2", 32'(bus.engine_rst), 1);
            @(negedge clk);
            chk("switch_erst_rel", 32'(bus.engine_rst), 0);
            chk("switch_busy", 32'(bus.busy), 1);
        end else begin
            chk("idle_busy", 32'(bus.busy), 0);
            @(negedge clk);
            chk("idle_done_low", 32'(bus.list_done), 0);
            chk("idle_erst", 32'(bus.engine_rst), 1);
            chk("idle_busy2", 32'(bus.busy), 0);
            m_idle = 1'b1;
        end
    endtask

    initial begin
        logic [NL*AW-1:0] b2;
        logic [NL*AW-1:0] b3;
        logic [NL*AW-1:0] nb;
        logic [NL-1:0]    nm;
        int               seq [4];
        n_chk  = 0;
        n_err  = 0;
        rst    = 1'b1;
        bus.enable_mask = '0;
        bus.list_base   = '0;
        bus.repeat_cnt  = '0;
        bus.engine_addr = '0;
        bus.frame_drawn = 1'b0;
        m_cur  = NL - 1;
        m_base = '0;
        m_rep  = 1;
        m_idle = 1'b1;

        // Reset and idle with an empty mask
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            bus.engine_addr = AW'($urandom);
            @(negedge clk);
            chk("idle_erst", 32'(bus.engine_rst), 1);
            chk("idle_busy", 32'(bus.busy), 0);
            chk("idle_done", 32'(bus.list_done), 0);
            chk("idle_rom", 32'(bus.rom_addr), 32'(bus.engine_addr));
        end
        chk("reset_active", 32'(bus.active_list), 3);

        // Two lists, repeat 2: order 0,2,0,2
        b2  = {10'd300, 10'd200, 10'd100, 10'd0};
        seq = '{0, 2, 0, 2};
        start_idle(4'b0101, b2, 4'd2);
        chk("seq0", 32'(bus.active_list), 32'(seq[0]));
        for (int v = 1; v < 4; v++) begin
            do_visit(4'b0101, b2, 4'd2, 1'b0);
            chk("seq", 32'(bus.active_list), 32'(seq[v]));
        end
        bus.engine_addr = 10'd37;
        #1;
        chk("list2_rom", 32'(bus.rom_addr), 237);
        do_visit(4'b0000, b2, 4'd2, 1'b0);

        // Single list, repeat 0 (acts as 1), base near the top of the ROM
        b3 = {10'd0, 10'd0, 10'd1020, 10'd0};
        start_idle(4'b0010, b3, 4'd0);
        chk("single_active", 32'(bus.active_list), 1);
        bus.engine_addr = 10'd10;
        #1;
        chk("wrap_rom", 32'(bus.rom_addr), 6);
        do_visit(4'b0010, b3, 4'd0, 1'b0);
        do_visit(4'b0010, b3, 4'd0, 1'b0);
        do_visit(4'b0000, b3, 4'd0, 1'b0);

        // Mask cleared mid-visit: the 3-frame visit still completes
        start_idle(4'b0100, b2, 4'd3);
        bus.enable_mask = 4'b0000;
        do_visit(4'b0000, b2, 4'd0, 1'b1);
        repeat (3) begin
            @(negedge clk);
            chk("cleared_erst", 32'(bus.engine_rst), 1);
            chk("cleared_busy", 32'(bus.busy), 0);
        end

        // Asynchronous reset in the middle of a visit
        start_idle(4'b0010, b2, 4'd2);
        repeat (3) @(negedge clk);
        bus.engine_addr = 10'd123;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_erst", 32'(bus.engine_rst), 1);
        chk("arst_busy", 32'(bus.busy), 0);
        chk("arst_done", 32'(bus.list_done), 0);
        chk("arst_active", 32'(bus.active_list), 3);
        chk("arst_rom", 32'(bus.rom_addr), 123);
        m_cur  = NL - 1;
        m_base = '0;
        m_rep  = 1;
        m_idle = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        start_idle(4'b1000, b2, 4'd1);
        chk("arst_resume", 32'(bus.active_list), 3);

        // Randomized visits
        for (int it = 0; it < 30; it++) begin
            nb = (NL*AW)'({$urandom, $urandom});
            if (m_idle) begin
                nm = NL'($urandom_range(1, 15));
                start_idle(nm, nb, RW'($urandom_range(0, 3)));
            end else begin
                nm = ($urandom_range(0, 5) == 0) ? '0 : NL'($urandom_range(1, 15));
                do_visit(nm, nb, RW'($urandom_range(0, 3)), 1'b1);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
